// File: rtl/spi_shift_engine.sv
// spi_shift_engine: parametrised SPI serial/parallel shift register with bit counter and word-complete strobe.
//   clk                  system clock, all state on rising edge
//   resetN               asynchronous active-low reset
//   peripheralClkEdge    SCLK rising-edge pulse: shift/sample
//   peripheralClkNegEdge SCLK falling-edge pulse: launch serial output bit
//   parallelLoad         load parallelDataIn (highest priority)
//   lsbFirst             0 = MSB-first, 1 = LSB-first
//   clearCount           zero the bit counter, data untouched
//   parallelDataIn       parallel load value
//   serialDataIn         serial input bit sampled on shift
//   parallelDataOut      shift register contents
//   serialDataOut        registered serial output bit
//   bitCount             bits shifted in current word
//   wordDone             one-clk pulse after the WIDTH-th shift
module spi_shift_engine #(
  parameter int WIDTH = 8,
  parameter int CW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             peripheralClkEdge,
  input  logic             peripheralClkNegEdge,
  input  logic             parallelLoad,
  input  logic             lsbFirst,
  input  logic             clearCount,
  input  logic [WIDTH-1:0] parallelDataIn,
  input  logic             serialDataIn,
  output logic [WIDTH-1:0] parallelDataOut,
  output logic             serialDataOut,
  output logic [CW-1:0]    bitCount,
  output logic             wordDone
);
  localparam logic [CW-1:0] last = CW'(WIDTH - 1);
  logic [WIDTH-1:0] shifted;
  logic             load_head;
  logic             reg_head;
  logic             wrap;
  always_comb begin
    shifted   = lsbFirst ? {serialDataIn, parallelDataOut[WIDTH-1:1]}
                         : {parallelDataOut[WIDTH-2:0], serialDataIn};
    load_head = lsbFirst ? parallelDataIn[0] : parallelDataIn[WIDTH-1];
    reg_head  = lsbFirst ? parallelDataOut[0] : parallelDataOut[WIDTH-1];
    wrap      = bitCount == last;
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      parallelDataOut <= '0;
      serialDataOut   <= 1'b0;
      bitCount        <= '0;
      wordDone        <= 1'b0;
    end else if (parallelLoad) begin
      parallelDataOut <= parallelDataIn;
      serialDataOut   <= load_head;
      bitCount        <= '0;
      wordDone        <= 1'b0;
    end else begin
      if (peripheralClkEdge) parallelDataOut <= shifted;
      // reg_head is taken from the pre-shift value, so a coincident shift cannot disturb the launched bit
      if (peripheralClkNegEdge) serialDataOut <= reg_head;
      bitCount <= clearCount ? '0 : !peripheralClkEdge ? bitCount : wrap ? '0 : bitCount + 1'b1;
      wordDone <= peripheralClkEdge && wrap && !clearCount;
    end
  end
endmodule
